mem_block_reader: RTL and testbench

//  Memory-side responder for the sys::mem_read_block_req_t / sys::mem_read_block_rsp_t protocol.

---
 rtl/mem_block_reader_pkg.sv | 28 ++
 rtl/mem_block_reader_rr_arbiter.sv | 27 ++
 rtl/mem_block_reader.sv | 174 +++++++++++++++++
 tb/tb_mem_block_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_block_reader_pkg.sv
// Shared types for the block-read protocol between cache miss ports and main memory.
// The optional statistics counters in mem_block_reader are enabled by MEM_BLOCK_READER_STATS_EN.
package mem_block_reader_pkg;

    localparam int addr_width     = 32;
    localparam int mem_block_size = 16;
    localparam int mem_word_bytes = 4;

    typedef struct packed {
        logic                  valid;
        logic [addr_width-1:0] addr;
    } mem_read_block_req_t;

    typedef struct packed {
        logic                        done;
        logic [8*mem_block_size-1:0] data;
    } mem_read_block_rsp_t;

    localparam mem_read_block_rsp_t mem_read_block_rsp_rst = '0;

    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    // Index widths must stay at least one bit even for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_block_reader_rr_arbiter.sv
// Combinational round-robin picker: first valid port at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int port_cnt  = 2,
    parameter int ptr_width = 1
) (
    input  logic [port_cnt-1:0]  valid,
    input  logic [ptr_width-1:0] rr_ptr,
    output logic [ptr_width-1:0] grant,
    output logic                 grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < port_cnt; k++) begin
            idx = (int'(rr_ptr) + k) % port_cnt;
            if (!grant_valid && valid[idx]) begin
                grant       = ptr_width'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_block_reader.sv
// Serves block reads from several requesters by streaming word reads from a fixed-latency RAM.
// Define MEM_BLOCK_READER_STATS_EN to add the stat_blocks / stat_busy saturating counters.
module mem_block_reader
    import mem_block_reader_pkg::*;
#(
    parameter int port_cnt   = 2,
    parameter int word_bytes = mem_word_bytes,
    parameter int rd_latency = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  mem_read_block_req_t     req [port_cnt],
    output mem_read_block_rsp_t     rsp [port_cnt],
    output logic                    mem_rd_en,
    output logic [addr_width-1:0]   mem_rd_addr,
    input  logic [8*word_bytes-1:0] mem_rd_data
`ifdef MEM_BLOCK_READER_STATS_EN
    ,
    output logic [31:0]             stat_blocks,
    output logic [31:0]             stat_busy
`endif
);

    localparam int beat_cnt   = mem_block_size / word_bytes;
    localparam int ptr_width  = clog2_min1(port_cnt);
    localparam int beat_width = clog2_min1(beat_cnt);
    localparam int word_bits  = 8 * word_bytes;
    localparam int block_bits = 8 * mem_block_size;
    localparam logic [beat_width-1:0] last_beat = beat_width'(beat_cnt - 1);

    state_t                  state;
    logic [ptr_width-1:0]    rr_ptr;
    logic [ptr_width-1:0]    grant_q;
    logic [ptr_width-1:0]    arb_grant;
    logic [ptr_width-1:0]    next_ptr;
    logic                    arb_valid;
    logic [port_cnt-1:0]     req_valid;
    logic [addr_width-1:0]   arb_base;
    logic                    grant_alive;
    logic [beat_width-1:0]   beat;
    logic [beat_width-1:0]   cap_cnt;
    logic [rd_latency-1:0]   rd_vld;
    logic                    capture;
    logic                    abandon;
    logic [block_bits-1:0]   block_q;
    logic [block_bits-1:0]   block_next;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < port_cnt; i++) begin
            req_valid[i] = req[i].valid;
        end
    end

    rr_arbiter #(
        .port_cnt (port_cnt),
        .ptr_width(ptr_width)
    ) u_arb (
        .valid      (req_valid),
        .rr_ptr     (rr_ptr),
        .grant      (arb_grant),
        .grant_valid(arb_valid)
    );

    assign arb_base    = req[arb_grant].addr & ~addr_width'(mem_block_size - 1);
    assign grant_alive = req[grant_q].valid;
    assign capture     = rd_vld[rd_latency-1];
    assign next_ptr    = (grant_q == ptr_width'(port_cnt - 1)) ? '0 : grant_q + 1'b1;

    // The last word lands on the same edge that enters RESP, so the response is built from this bypass.
    always_comb begin
        block_next = block_q;
        if (capture) begin
            block_next[int'(cap_cnt)*word_bits +: word_bits] = mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_q     <= '0;
            beat        <= '0;
            cap_cnt     <= '0;
            rd_vld      <= '0;
            abandon     <= 1'b0;
            block_q     <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            for (int i = 0; i < port_cnt; i++) begin
                rsp[i] <= mem_read_block_rsp_rst;
            end
        end else begin
            rd_vld <= (rd_vld << 1) | rd_latency'(mem_rd_en);
            if (capture) begin
                block_q <= block_next;
                cap_cnt <= cap_cnt + 1'b1;
            end
            for (int i = 0; i < port_cnt; i++) begin
                rsp[i].done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (en && arb_valid) begin
                        grant_q     <= arb_grant;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= arb_base;
                        beat        <= '0;
                        cap_cnt     <= '0;
                        abandon     <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (!grant_alive) begin
                        abandon <= 1'b1;
                    end
                    if (beat == last_beat) begin
                        mem_rd_en <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        beat        <= beat + 1'b1;
                        mem_rd_addr <= mem_rd_addr + addr_width'(word_bytes);
                    end
                end
                WAIT: begin
                    if (!grant_alive) begin
                        abandon <= 1'b1;
                    end
                    if (capture && cap_cnt == last_beat) begin
                        state <= RESP;
                        // A requester that gave up at any point gets no done pulse.
                        if (!abandon && grant_alive) begin
                            rsp[grant_q].done <= 1'b1;
                            rsp[grant_q].data <= block_next;
                        end
                    end
                end
                RESP: begin
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_BLOCK_READER_STATS_EN
    logic any_done;

    always_comb begin
        any_done = 1'b0;
        for (int i = 0; i < port_cnt; i++) begin
            any_done = any_done | rsp[i].done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_blocks <= '0;
            stat_busy   <= '0;
        end else begin
            if (any_done && stat_blocks != '1) begin
                stat_blocks <= stat_blocks + 32'd1;
            end
            if (state != IDLE && stat_busy != '1) begin
                stat_busy <= stat_busy + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_block_reader.sv
// Directed bench for mem_block_reader: block size 16, 4-byte words, RAM latency 1, word[a] = a.
module tb_mem_block_reader;
    import mem_block_reader_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    mem_read_block_req_t req [2];
    mem_read_block_rsp_t rsp [2];
    logic                mem_rd_en;
    logic [31:0]         mem_rd_addr;
    logic [31:0]         mem_rd_data;
`ifdef MEM_BLOCK_READER_STATS_EN
    logic [31:0]         stat_blocks;
    logic [31:0]         stat_busy;
`endif

    int checks = 0;
    int errors = 0;

    int          done_cnt [2] = '{0, 0};
    logic        prev_done [2] = '{1'b0, 1'b0};
    int          both_cnt = 0;
    int          consec_cnt = 0;
    int          done_q [$];
    logic [31:0] rd_q [$];

    typedef struct {
        int           port;
        logic [31:0]  addr;
        logic [31:0]  base;
        logic [127:0] data;
    } vec_t;

    vec_t vecs [4];

    mem_block_reader dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .rsp        (rsp),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data)
`ifdef MEM_BLOCK_READER_STATS_EN
        ,
        .stat_blocks(stat_blocks),
        .stat_busy  (stat_busy)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle RAM whose word at each address equals the address.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_rd_addr : 32'h0;
    end

    always @(negedge clk) begin
        if (mem_rd_en) rd_q.push_back(mem_rd_addr);
        if (rsp[0].done && rsp[1].done) both_cnt++;
        for (int i = 0; i < 2; i++) begin
            if (rsp[i].done) begin
                done_cnt[i]++;
                done_q.push_back(i);
                if (prev_done[i]) consec_cnt++;
            end
            prev_done[i] = rsp[i].done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] addr);
        req[port].valid = 1'b1;
        req[port].addr  = addr;
    endtask

    task automatic waitDone(input int port, input int budget, output int cycles, output logic seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if (rsp[port].done) seen = 1'b1;
        end
    endtask

    task automatic checkReads(input string name, input logic [31:0] base);
        checkOutput({name, "_rd_count"}, 128'(rd_q.size()), 128'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput({name, "_rd_addr"}, (k < rd_q.size()) ? rd_q[k] : 32'hDEAD_BEEF, base + 32'(4 * k));
        end
    endtask

    initial begin
        int   cycles;
        logic seen;
        int   p1_before;

        vecs[0] = '{0, 32'h0000_0107, 32'h0000_0100, 128'h0000010c_00000108_00000104_00000100};
        vecs[1] = '{1, 32'h0000_0020, 32'h0000_0020, 128'h0000002c_00000028_00000024_00000020};
        vecs[2] = '{0, 32'hFFFF_FFF3, 32'hFFFF_FFF0, 128'hfffffffc_fffffff8_fffffff4_fffffff0};
        vecs[3] = '{1, 32'h0000_001F, 32'h0000_0010, 128'h0000001c_00000018_00000014_00000010};

        rst = 1'b0;
        en  = 1'b1;
        req[0] = '0;
        req[1] = '0;
        tick();
        tick();
        checkOutput("rst_rd_en", 128'(mem_rd_en), 128'd0);
        checkOutput("rst_rd_addr", 128'(mem_rd_addr), 128'd0);
        checkOutput("rst_rsp0", 128'(rsp[0]), 128'd0);
        checkOutput("rst_rsp1", 128'(rsp[1]), 128'd0);
        rst = 1'b1;
        tick();

        // Single-port transfers from the vector table.
        for (int v = 0; v < 4; v++) begin
            rd_q.delete();
            applyStimulus(vecs[v].port, vecs[v].addr);
            waitDone(vecs[v].port, 20, cycles, seen);
            req[vecs[v].port].valid = 1'b0;
            checkOutput("vec_done_seen", 128'(seen), 128'd1);
            checkOutput("vec_latency", 128'(cycles), 128'd6);
            checkOutput("vec_data", rsp[vecs[v].port].data, vecs[v].data);
            checkReads("vec", vecs[v].base);
            tick();
            checkOutput("vec_done_pulse", 128'(rsp[vecs[v].port].done), 128'd0);
            checkOutput("vec_data_hold", rsp[vecs[v].port].data, vecs[v].data);
            tick();
        end

        // Both ports held valid: grants must alternate.
        done_q.delete();
        applyStimulus(0, 32'h0000_0040);
        applyStimulus(1, 32'h0000_0080);
        cycles = 0;
        while (done_q.size() < 4 && cycles < 60) begin
            tick();
            cycles++;
        end
        req[0].valid = 1'b0;
        req[1].valid = 1'b0;
        checkOutput("rr_count", 128'(done_q.size()), 128'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("rr_order", (k < done_q.size()) ? 128'(done_q[k]) : 128'hF, 128'(k % 2));
        end
        checkOutput("rr_data1", rsp[1].data, 128'h0000008c_00000088_00000084_00000080);
        checkOutput("rr_both_done", 128'(both_cnt), 128'd0);
        repeat (3) tick();

        // Port 1 abandons during READ.
        rd_q.delete();
        p1_before = done_cnt[1];
        applyStimulus(1, 32'h0000_0300);
        tick();
        tick();
        req[1].valid = 1'b0;
        repeat (8) tick();
        checkOutput("abandon_no_done", 128'(done_cnt[1] - p1_before), 128'd0);
        checkReads("abandon", 32'h0000_0300);
        checkOutput("abandon_idle_rd_en", 128'(mem_rd_en), 128'd0);
        applyStimulus(0, 32'h0000_0400);
        waitDone(0, 20, cycles, seen);
        req[0].valid = 1'b0;
        checkOutput("after_abandon_seen", 128'(seen), 128'd1);
        checkOutput("after_abandon_latency", 128'(cycles), 128'd6);
        checkOutput("after_abandon_data", rsp[0].data, 128'h0000040c_00000408_00000404_00000400);
        repeat (2) tick();

        // Reset during READ beat 2, request stays pending.
        applyStimulus(0, 32'h0000_0500);
        repeat (3) tick();
        checkOutput("mid_beat2_addr", 128'(mem_rd_addr), 128'h508);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid_rst_rd_en", 128'(mem_rd_en), 128'd0);
        checkOutput("mid_rst_rd_addr", 128'(mem_rd_addr), 128'd0);
        checkOutput("mid_rst_rsp0", 128'(rsp[0]), 128'd0);
        checkOutput("mid_rst_rsp1", 128'(rsp[1]), 128'd0);
        tick();
        rd_q.delete();
        rst = 1'b1;
        waitDone(0, 20, cycles, seen);
        req[0].valid = 1'b0;
        checkOutput("restart_seen", 128'(seen), 128'd1);
        checkOutput("restart_latency", 128'(cycles), 128'd6);
        checkOutput("restart_data", rsp[0].data, 128'h0000050c_00000508_00000504_00000500);
        checkReads("restart", 32'h0000_0500);
        repeat (2) tick();

        // en gates only the start of a transfer.
        rd_q.delete();
        en = 1'b0;
        applyStimulus(0, 32'h0000_0600);
        repeat (10) tick();
        checkOutput("en_low_reads", 128'(rd_q.size()), 128'd0);
        checkOutput("en_low_rd_en", 128'(mem_rd_en), 128'd0);
        en = 1'b1;
        tick();
        checkOutput("en_grant_rd_en", 128'(mem_rd_en), 128'd1);
        checkOutput("en_grant_addr", 128'(mem_rd_addr), 128'h600);
        en = 1'b0;
        waitDone(0, 20, cycles, seen);
        req[0].valid = 1'b0;
        checkOutput("en_drop_seen", 128'(seen), 128'd1);
        checkOutput("en_drop_latency", 128'(cycles), 128'd5);
        checkOutput("en_drop_data", rsp[0].data, 128'h0000060c_00000608_00000604_00000600);
        en = 1'b1;
        repeat (2) tick();

`ifdef MEM_BLOCK_READER_STATS_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("stat_rst_blocks", 128'(stat_blocks), 128'd0);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(b % 2, 32'h0000_0700 + 32'(b * 16));
            waitDone(b % 2, 20, cycles, seen);
            req[b % 2].valid = 1'b0;
            checkOutput("stat_seen", 128'(seen), 128'd1);
            repeat (2) tick();
        end
        checkOutput("stat_blocks", 128'(stat_blocks), 128'd3);
        checkOutput("stat_busy", 128'(stat_busy), 128'd18);
`endif

        checkOutput("no_double_done", 128'(consec_cnt), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
